// File: rtl/switch_box_config_loader_pkg.sv
// -----------------------------------------------------------------------------
// switch_box_config_loader_pkg
//
// Shared definitions for the switch-box configuration loader and its bench:
//   - FSM state encodings as localparams plus the enum built on top of them.
//   - cnt_width(): width of a counter that must hold values 0..n-1. It never
//     returns 0, so degenerate parameters (W=1 or N_WORDS=1) still give a
//     legal one-bit counter.
// -----------------------------------------------------------------------------
package switch_box_config_loader_pkg;

  // State encodings. Kept as named localparams so the bench and any debug
  // logic can refer to the same values the FSM uses.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC  = 2'd1;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  // Bits needed to count 0..n-1, with a floor of one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/switch_box_config_loader_piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
//
// Parallel-in / serial-out register feeding the switch-box chain. A load
// captures a whole word; each shift moves it right by one so the next bit
// appears on q_lsb. Load has priority over shift.
//
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset, clears the register
//   load   in  capture d
//   shift  in  shift right by one, zero filled from the top
//   d      in  [W-1:0] parallel word
//   q_lsb  out current serial bit (register bit 0)
// -----------------------------------------------------------------------------
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_lsb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      // Logical shift keeps this valid for W=1 as well.
      sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_lsb = sr_q[0];

endmodule

// File: rtl/switch_box_config_loader.sv
// -----------------------------------------------------------------------------
// switch_box_config_loader
//
// Streams N_WORDS configuration words of W bits each into a serial switch-box
// chain, LSB first, word 0 first. Each word is taken with a valid/ready
// handshake in LOAD and then shifted out over exactly W SHIFT cycles. After
// the last bit of the last word, DONE raises a one-cycle done pulse.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin a load; only looked at while idle
//   word_in     in   [W-1:0] parallel configuration word
//   word_valid  in   word_in holds a valid word
//   word_ready  out  loader takes word_in this cycle (LOAD only)
//   cfg_out     out  serial bit to the chain (0 outside SHIFT)
//   cfg_en      out  chain shift enable (SHIFT only)
//   busy        out  load in progress
//   done        out  one-cycle pulse after the last bit
//
// All outputs are decoded from registered state only, so an asserted rst
// drives them to 0 in the same cycle.
// -----------------------------------------------------------------------------
module switch_box_config_loader
  import switch_box_config_loader_pkg::*;
#(
  parameter int W       = 8,
  parameter int N_WORDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic         cfg_out,
  output logic         cfg_en,
  output logic         busy,
  output logic         done
);

  localparam int BIT_W  = cnt_width(W);
  localparam int WORD_W = cnt_width(N_WORDS);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(N_WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_d;
  logic [WORD_W-1:0] word_cnt_q;
  logic [WORD_W-1:0] word_cnt_d;

  logic sr_load;
  logic sr_shift;
  logic sr_lsb;

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  piso_shift_reg #(
    .W (W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (word_in),
    .q_lsb (sr_lsb)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    word_ready = 1'b0;
    cfg_out    = 1'b0;
    cfg_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      ST_LOAD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          sr_load   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        cfg_en   = 1'b1;
        cfg_out  = sr_lsb;
        sr_shift = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (word_cnt_q == WORD_LAST) begin
            state_d = ST_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = ST_LOAD;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        // start is deliberately not examined here; a request coinciding with
        // done is dropped rather than chaining a second load.
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
